// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI responder exposing an 8-bit register file with burst read/write
// All SPI pins are oversampled in the clk domain; sclk is never used as a clock.
module spi_reg_slave #(
    parameter int   NREGS = 16,
    parameter logic CPOL  = 1'b0,
    parameter logic CPHA  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t      state, state_d;
    logic [1:0]  sclk_sync, cs_sync, mosi_sync;
    logic        sclk_q, cs_q;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  tx_sr;
    logic [6:0]  addr;
    logic        load_pend, wr_pend;
    logic [7:0]  regs [NREGS];

    logic        lead_edge, trail_edge, sample_edge, shift_edge;
    logic        cs_fall, cs_rise, byte_done, addr_ok, wr_en;
    logic [7:0]  rx_next;

    // cs chain resets low so a cs already asserted at reset release never looks like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {2{CPOL}};
            sclk_q    <= CPOL;
            cs_sync   <= 2'b00;
            cs_q      <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            sclk_q    <= sclk_sync[1];
            cs_sync   <= {cs_sync[0], cs};
            cs_q      <= cs_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign lead_edge   = (sclk_q == CPOL) && (sclk_sync[1] != CPOL);
    assign trail_edge  = (sclk_q != CPOL) && (sclk_sync[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_q && !cs_sync[1];
    assign cs_rise     = !cs_q && cs_sync[1];
    assign byte_done   = sample_edge && (bit_cnt == 3'd7);
    assign rx_next     = {rx_sr, mosi_sync[1]};
    assign addr_ok     = ({25'd0, addr} < NREGS);
    assign wr_en       = (state == WDATA) && byte_done && !cs_rise && addr_ok;

    assign busy = (state != IDLE);
    assign miso = (state != IDLE) && tx_sr[7];

    function automatic logic [7:0] reg_at(input logic [6:0] a);
        reg_at = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (a == 7'(i)) reg_at = regs[i];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (cs_fall) state_d = CMD;
            CMD: begin
                if (cs_rise)        state_d = IDLE;
                else if (byte_done) state_d = rx_next[7] ? RDATA : WDATA;
            end
            WDATA: if (cs_rise) state_d = IDLE;
            RDATA: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // bit_cnt == 0 on a shift edge marks the byte's first bit already on miso (CPHA=1 leading
    // edge) or the trailing edge right after a reload (CPHA=0), so that shift is suppressed
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'h00;
            addr      <= 7'd0;
            load_pend <= 1'b0;
            wr_pend   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
        end else begin
            wr_pend   <= 1'b0;
            wr_strobe <= wr_pend;
            load_pend <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
                if (cs_fall) begin
                    tx_sr <= 8'h00;
                    rx_sr <= 7'd0;
                end
            end else if (cs_rise) begin
                bit_cnt <= 3'd0;
            end else begin
                if (sample_edge) begin
                    rx_sr   <= rx_next[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (load_pend)
                    tx_sr <= reg_at(addr);
                else if (shift_edge && bit_cnt != 3'd0)
                    tx_sr <= {tx_sr[6:0], 1'b0};
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            addr      <= rx_next[6:0];
                            load_pend <= rx_next[7];
                        end
                        RDATA: begin
                            addr      <= addr + 7'd1;
                            load_pend <= 1'b1;
                        end
                        WDATA: begin
                            if (addr_ok) begin
                                wr_pend <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= rx_next;
                            end
                            addr <= addr + 7'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst)                         regs[i] <= 8'h00;
            else if (wr_en && addr == 7'(i)) regs[i] <= rx_next;
        end
        if (rst) rd_data <= 8'h00;
        else     rd_data <= reg_at(rd_addr);
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - randomized bench for spi_reg_slave in three SPI modes against a register model
module tb_spi_reg_slave;

    localparam int         H   = 80;
    localparam logic [2:0] POL = 3'b100;
    localparam logic [2:0] PHA = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sclk_v, cs_v, mosi_v, miso_v, wr_strobe_v, busy_v;
    logic [6:0] wr_addr_v [3];
    logic [7:0] wr_data_v [3];
    logic [7:0] rd_data_v [3];
    logic [6:0] rd_addr;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_reg_slave #(.NREGS(16), .CPOL(POL[g]), .CPHA(PHA[g])) dut (
            .clk(clk), .rst(rst), .sclk(sclk_v[g]), .cs(cs_v[g]), .mosi(mosi_v[g]),
            .miso(miso_v[g]), .wr_strobe(wr_strobe_v[g]), .wr_addr(wr_addr_v[g]),
            .wr_data(wr_data_v[g]), .rd_addr(rd_addr), .rd_data(rd_data_v[g]), .busy(busy_v[g])
        );
    end

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [16];
    logic [14:0] exp_wr [$];
    int          scnt [3];
    logic [7:0]  txb [$];
    logic [7:0]  rxb [3][16];
    logic [7:0]  exp_rx [16];
    logic        quiet = 1'b0;
    logic        pin_en = 1'b0;
    logic [6:0]  pin_addr = 7'd0;

    function automatic logic [7:0] mreg(input logic [6:0] a);
        return (a < 7'd16) ? model[a[3:0]] : 8'h00;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst %0d got %0h expected %0h", name, inst, act, req);
        end
    endtask

    // every cycle: strobes against the expected write list, and when idle rd_data/busy/miso
    initial begin : compare
        logic [6:0] last_addr;
        logic       quiet_prev;
        last_addr  = 7'd0;
        quiet_prev = 1'b0;
        rd_addr    = 7'd0;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                if (wr_strobe_v[m]) begin
                    if (scnt[m] >= exp_wr.size())
                        chk("strobe_unexpected", m, {17'd0, wr_addr_v[m], wr_data_v[m]}, 32'hFFFF_FFFF);
                    else
                        chk("strobe_addr_data", m, {17'd0, wr_addr_v[m], wr_data_v[m]}, {17'd0, exp_wr[scnt[m]]});
                    scnt[m]++;
                end
                if (quiet && quiet_prev) begin
                    chk("rd_data", m, {24'd0, rd_data_v[m]}, {24'd0, mreg(last_addr)});
                    chk("busy_idle", m, {31'd0, busy_v[m]}, 32'd0);
                    chk("miso_idle", m, {31'd0, miso_v[m]}, 32'd0);
                end
            end
            quiet_prev = quiet;
            rd_addr    = pin_en ? pin_addr : 7'($urandom_range(0, 127));
            last_addr  = rd_addr;
        end
    end

    task automatic spi_bit(input logic b, output logic [2:0] got);
        for (int m = 0; m < 3; m++) begin
            if (PHA[m]) sclk_v[m] = ~POL[m];
            mosi_v[m] = b;
        end
        #(H);
        got = miso_v;
        for (int m = 0; m < 3; m++) sclk_v[m] = PHA[m] ? POL[m] : ~POL[m];
        #(H);
        for (int m = 0; m < 3; m++) if (!PHA[m]) sclk_v[m] = POL[m];
    endtask

    task automatic spi_xfer(input int abort_bits);
        logic [2:0] got;
        int nb;
        quiet = 1'b0;
        cs_v  = 3'b000;
        #(H);
        for (int i = 0; i < txb.size(); i++) begin
            nb = (i == txb.size() - 1 && abort_bits > 0) ? abort_bits : 8;
            for (int j = 0; j < nb; j++) begin
                spi_bit(txb[i][7-j], got);
                for (int m = 0; m < 3; m++) rxb[m][i][7-j] = got[m];
            end
        end
        #(H);
        cs_v = 3'b111;
        #(2*H);
        quiet = 1'b1;
    endtask

    // register-file view of a transfer: only completed bytes after the command have any effect
    task automatic model_xfer(input int full);
        logic [6:0] a;
        if (full == 0) return;
        a = txb[0][6:0];
        exp_rx[0] = 8'h00;
        for (int i = 1; i < full; i++) begin
            if (txb[0][7]) begin
                exp_rx[i] = mreg(a);
            end else begin
                exp_rx[i] = 8'h00;
                if (a < 7'd16) begin
                    model[a[3:0]] = txb[i];
                    exp_wr.push_back({a, txb[i]});
                end
            end
            a = a + 7'd1;
        end
    endtask

    task automatic run_xfer(input int abort_bits);
        int full;
        full = (abort_bits > 0) ? txb.size() - 1 : txb.size();
        model_xfer(full);
        spi_xfer(abort_bits);
        for (int i = 0; i < full; i++)
            for (int m = 0; m < 3; m++)
                chk("miso_byte", m, {24'd0, rxb[m][i]}, {24'd0, exp_rx[i]});
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        txb.delete();
        txb.push_back(b0);
        if (n > 1) txb.push_back(b1);
        if (n > 2) txb.push_back(b2);
    endtask

    task automatic pin_read(input logic [6:0] a, input logic [7:0] req, input string name);
        pin_en   = 1'b1;
        pin_addr = a;
        #30;
        for (int m = 0; m < 3; m++) chk(name, m, {24'd0, rd_data_v[m]}, {24'd0, req});
        pin_en = 1'b0;
    endtask

    initial begin : stimulus
        logic [2:0] got;
        logic [6:0] a;
        int n, ab;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int m = 0; m < 3; m++) scnt[m] = 0;
        rst    = 1'b1;
        cs_v   = 3'b111;
        sclk_v = POL;
        mosi_v = 3'b000;
        #100;
        for (int m = 0; m < 3; m++) begin
            chk("rst_miso", m, {31'd0, miso_v[m]}, 32'd0);
            chk("rst_busy", m, {31'd0, busy_v[m]}, 32'd0);
            chk("rst_strobe", m, {31'd0, wr_strobe_v[m]}, 32'd0);
            chk("rst_wr", m, {17'd0, wr_addr_v[m], wr_data_v[m]}, 32'd0);
            chk("rst_rd_data", m, {24'd0, rd_data_v[m]}, 32'd0);
        end
        rst = 1'b0;
        #50;
        quiet = 1'b1;
        #50;

        set_tx(8'h03, 8'h2B, 8'h5A, 3);
        run_xfer(0);
        chk("model_wr0", 0, {17'd0, exp_wr[0]}, {17'd0, 7'd3, 8'h2B});
        chk("model_wr1", 0, {17'd0, exp_wr[1]}, {17'd0, 7'd4, 8'h5A});
        for (int m = 0; m < 3; m++) chk("strobe_count", m, scnt[m], 2);
        pin_read(7'd4, 8'h5A, "rd_reg4");

        set_tx(8'h83, 8'h00, 8'h00, 3);
        run_xfer(0);
        for (int m = 0; m < 3; m++) begin
            chk("rd_burst_b0", m, {24'd0, rxb[m][0]}, 32'h00);
            chk("rd_burst_b1", m, {24'd0, rxb[m][1]}, 32'h2B);
            chk("rd_burst_b2", m, {24'd0, rxb[m][2]}, 32'h5A);
        end

        set_tx(8'h0F, 8'h11, 8'h22, 3);
        run_xfer(0);
        for (int m = 0; m < 3; m++) chk("strobe_count_top", m, scnt[m], 3);
        set_tx(8'h8F, 8'h00, 8'h00, 3);
        run_xfer(0);
        for (int m = 0; m < 3; m++) begin
            chk("rd_top_b1", m, {24'd0, rxb[m][1]}, 32'h11);
            chk("rd_top_b2", m, {24'd0, rxb[m][2]}, 32'h00);
        end

        set_tx(8'h02, 8'hAB, 8'h00, 2);
        run_xfer(5);
        pin_read(7'd2, 8'h00, "abort_reg2");
        set_tx(8'h02, 8'h77, 8'h00, 2);
        run_xfer(0);
        pin_read(7'd2, 8'h77, "rewrite_reg2");

        for (int t = 0; t < 30; t++) begin
            a = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(126, 127)) : 7'($urandom_range(0, 19));
            n = $urandom_range(1, 4);
            txb.delete();
            txb.push_back({1'($urandom_range(0, 1)), a});
            for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            run_xfer(ab);
            #(10 * $urandom_range(2, 10));
        end

        quiet  = 1'b0;
        cs_v   = 3'b000;
        #(H);
        txb.delete();
        txb.push_back(8'h80);
        for (int j = 0; j < 8; j++) spi_bit(txb[0][7-j], got);
        for (int j = 0; j < 3; j++) spi_bit(1'b0, got);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        #30;
        for (int m = 0; m < 3; m++) begin
            chk("rst_mid_miso", m, {31'd0, miso_v[m]}, 32'd0);
            chk("rst_mid_busy", m, {31'd0, busy_v[m]}, 32'd0);
        end
        quiet = 1'b1;
        #30;
        rst = 1'b0;
        txb.delete();
        txb.push_back(8'h01);
        txb.push_back(8'hFF);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) spi_bit(txb[i][7-j], got);
        cs_v = 3'b111;
        #(2*H);
        for (int a2 = 0; a2 < 16; a2++) pin_read(7'(a2), 8'h00, "rst_cleared");
        set_tx(8'h80, 8'h00, 8'h00, 2);
        run_xfer(0);
        for (int m = 0; m < 3; m++) chk("post_rst_read0", m, {24'd0, rxb[m][1]}, 32'h00);

        #100;
        for (int m = 0; m < 3; m++) chk("strobe_total", m, scnt[m], exp_wr.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
